// File: rtl/clk_lock_sequencer.sv
// Power-up reset sequencer for one PLL: pulses the PLL reset, qualifies LOCK through
// a filter with timeout/retry, then releases the domain resets one after another.
module clk_lock_sequencer #(
  parameter int N_RST       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int PLLRST_CYC  = 16,
  parameter int LOCK_FILTER = 1024,
  parameter int TIMEOUT     = 65536,
  parameter int STAGGER     = 8,
  parameter int MAX_RETRY   = 4
) (
  input  logic                           CLKI,
  input  logic                           RSTN,
  input  logic                           PLL_LOCK,
  output logic                           PLL_RST,
  output logic [N_RST-1:0]               RST_OUT,
  output logic                           READY,
  output logic                           FAIL,
  output logic [$clog2(MAX_RETRY+1)-1:0] RETRIES
);

  localparam int RW        = $clog2(MAX_RETRY + 1);
  localparam int FW        = $clog2(LOCK_FILTER + 1);
  localparam int TW        = $clog2(TIMEOUT + 1);
  localparam int REL_CYC   = STAGGER * N_RST;
  localparam int PHASE_MAX = (PLLRST_CYC > REL_CYC) ? PLLRST_CYC : REL_CYC;
  localparam int CW        = $clog2(PHASE_MAX + 1);

  localparam logic [CW-1:0] PLLRST_LAST = CW'(PLLRST_CYC - 1);
  localparam logic [CW-1:0] REL_LAST    = CW'(REL_CYC);
  localparam logic [FW-1:0] FILT_DONE   = FW'(LOCK_FILTER);
  localparam logic [TW-1:0] TMO_DONE    = TW'(TIMEOUT);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN,
    S_FAILED
  } state_e;

  logic [1:0]             rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_ok;
  logic                   lock_s;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [FW-1:0]    filt_q, filt_d, filt_inc;
  logic [TW-1:0]    tmo_q, tmo_d, tmo_inc;
  logic [RW-1:0]    retries_q, retries_d, retries_inc;
  logic             pll_rst_q, pll_rst_d;
  logic [N_RST-1:0] rst_out_q, rst_out_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             lock_lost;

  // Reset release is retimed so the FSM never leaves reset on a partial edge;
  // assertion stays fully asynchronous.
  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chains shift by one per clock.
      rst_sync_q  <= {rst_sync_q[0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], PLL_LOCK};
    end
  end

  assign rst_ok      = rst_sync_q[1];
  assign lock_s      = lock_sync_q[SYNC_STAGES-1];
  assign cnt_inc     = cnt_q + 1'b1;
  assign filt_inc    = filt_q + 1'b1;
  assign tmo_inc     = tmo_q + 1'b1;
  assign retries_inc = (retries_q == RETRY_MAX) ? retries_q : retries_q + 1'b1;

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_PLLRST;
      cnt_q     <= '0;
      filt_q    <= '0;
      tmo_q     <= '0;
      retries_q <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
      tmo_q     <= tmo_d;
      retries_q <= retries_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold default first, so no path through the case can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    filt_d    = filt_q;
    tmo_d     = tmo_q;
    retries_d = retries_q;
    pll_rst_d = pll_rst_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    fail_d    = fail_q;
    lock_lost = 1'b0;

    if (rst_ok) begin
      case (state_q)
        S_PLLRST: begin
          pll_rst_d = 1'b1;
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (cnt_q == PLLRST_LAST) begin
            state_d   = S_WAIT_LOCK;
            pll_rst_d = 1'b0;
            cnt_d     = '0;
            filt_d    = '0;
            tmo_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_WAIT_LOCK: begin
          filt_d = lock_s ? filt_inc : '0;
          tmo_d  = tmo_inc;
          // A filter completing on the timeout cycle counts as a lock.
          if (lock_s && (filt_inc == FILT_DONE)) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
          end else if (tmo_inc == TMO_DONE) begin
            retries_d = retries_inc;
            pll_rst_d = 1'b1;
            cnt_d     = '0;
            if (retries_inc < RETRY_MAX) begin
              state_d = S_PLLRST;
            end else begin
              state_d = S_FAILED;
              fail_d  = 1'b1;
            end
          end
        end

        S_RELEASE: begin
          if (!lock_s) begin
            lock_lost = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            for (int i = 0; i < N_RST; i++) begin
              rst_out_d[i] = (cnt_inc < CW'(STAGGER * (i + 1)));
            end
            if (cnt_inc == REL_LAST) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end
          end
        end

        S_RUN: begin
          if (!lock_s) lock_lost = 1'b1;
        end

        S_FAILED: begin
          pll_rst_d = 1'b1;
          rst_out_d = '1;
          ready_d   = 1'b0;
          fail_d    = 1'b1;
        end

        default: begin
          state_d   = S_PLLRST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end
      endcase

      // Losing lock after qualification re-holds every domain; the PLL itself is not reset.
      if (lock_lost) begin
        state_d   = S_WAIT_LOCK;
        cnt_d     = '0;
        filt_d    = '0;
        tmo_d     = '0;
        rst_out_d = '1;
        ready_d   = 1'b0;
      end
    end
  end

  assign PLL_RST = pll_rst_q;
  assign RST_OUT = rst_out_q;
  assign READY   = ready_q;
  assign FAIL    = fail_q;
  assign RETRIES = retries_q;

endmodule

// File: tb/tb_clk_lock_sequencer.sv
// Self-checking bench for clk_lock_sequencer: directed scenarios plus random lock
// waveforms, all compared each cycle against a timestamp-based reference model.
module tb_clk_lock_sequencer;

  localparam int N_RST       = 3;
  localparam int SYNC_STAGES = 2;
  localparam int PLLRST_CYC  = 4;
  localparam int LOCK_FILTER = 8;
  localparam int TIMEOUT     = 64;
  localparam int STAGGER     = 2;
  localparam int MAX_RETRY   = 2;
  localparam int RW          = $clog2(MAX_RETRY + 1);
  localparam int VW          = N_RST + RW + 3;

  localparam logic [VW-1:0] RESET_VEC = {1'b1, {N_RST{1'b1}}, 1'b0, 1'b0, {RW{1'b0}}};

  logic             clki = 1'b0;
  logic             rstn;
  logic             pll_lock;
  logic             pll_rst;
  logic [N_RST-1:0] rst_out;
  logic             ready;
  logic             fail_flag;
  logic [RW-1:0]    retries;

  int checks = 0;
  int errors = 0;

  clk_lock_sequencer #(
    .N_RST      (N_RST),
    .SYNC_STAGES(SYNC_STAGES),
    .PLLRST_CYC (PLLRST_CYC),
    .LOCK_FILTER(LOCK_FILTER),
    .TIMEOUT    (TIMEOUT),
    .STAGGER    (STAGGER),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .CLKI    (clki),
    .RSTN    (rstn),
    .PLL_LOCK(pll_lock),
    .PLL_RST (pll_rst),
    .RST_OUT (rst_out),
    .READY   (ready),
    .FAIL    (fail_flag),
    .RETRIES (retries)
  );

  always #5 clki = ~clki;

  // Reference model: a phase plus the clock edge at which it began; outputs are
  // derived from elapsed time, lock history is a plain delay line.
  typedef enum int {M_PLLRST, M_WAIT, M_REL, M_RUN, M_FAIL} mode_e;

  int    cyc = 0;
  mode_e m_mode;
  int    m_t0;
  int    m_run;
  int    m_retries;
  bit    ls0, ls1, rs0, rs1;

  task automatic model_reset();
    m_mode    = M_PLLRST;
    m_t0      = cyc;
    m_run     = 0;
    m_retries = 0;
    ls0 = 1'b0; ls1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0;
  endtask

  task automatic enter(input mode_e m);
    m_mode = m;
    m_t0   = cyc;
    m_run  = 0;
  endtask

  task automatic model_edge(input bit p);
    bit lk;
    bit act;
    cyc++;
    if (!rstn) begin
      model_reset();
      return;
    end
    lk  = ls1;
    act = rs1;
    ls1 = ls0; ls0 = p;
    rs1 = rs0; rs0 = 1'b1;
    if (!act) begin
      m_t0 = cyc;
      return;
    end
    case (m_mode)
      M_PLLRST: if (cyc - m_t0 == PLLRST_CYC) enter(M_WAIT);
      M_WAIT: begin
        m_run = lk ? m_run + 1 : 0;
        if (m_run == LOCK_FILTER) enter(M_REL);
        else if (cyc - m_t0 == TIMEOUT) begin
          if (m_retries < MAX_RETRY) m_retries++;
          enter((m_retries < MAX_RETRY) ? M_PLLRST : M_FAIL);
        end
      end
      M_REL: begin
        if (!lk) enter(M_WAIT);
        else if (cyc - m_t0 == STAGGER * N_RST) m_mode = M_RUN;
      end
      M_RUN: if (!lk) enter(M_WAIT);
      default: ;
    endcase
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N_RST-1:0] ro;
    for (int i = 0; i < N_RST; i++)
      ro[i] = !(m_mode == M_RUN || (m_mode == M_REL && (cyc - m_t0) >= STAGGER * (i + 1)));
    return {(m_mode == M_PLLRST || m_mode == M_FAIL), ro, (m_mode == M_RUN),
            (m_mode == M_FAIL), RW'(m_retries)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {pll_rst, rst_out, ready, fail_flag, retries};
  endfunction

  task automatic step(input bit p);
    pll_lock = p;
    @(posedge clki);
    model_edge(p);
    @(negedge clki);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    step(1'b0);
    step(1'b0);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    pll_lock = 1'b0;
    model_reset();
    step(1'b0);
    step(1'b0);
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_hold got %b want %b", dut_vec(), RESET_VEC);
    end
    rstn = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      step(1'b1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_run n=%0d got %b want %b", n, dut_vec(), exp_vec());
      end
    end
    #2 rstn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_async got %b want %b", dut_vec(), RESET_VEC);
    end
    step(1'b0);
  endtask

  task automatic test_nominal();
    int first_pll_low = 0;
    int first_r0      = 0;
    int first_ready   = 0;
    apply_reset();
    for (int n = 1; n <= 30; n++) begin
      step(1'b1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL nominal n=%0d got %b want %b", n, dut_vec(), exp_vec());
      end
      if (first_pll_low == 0 && pll_rst === 1'b0) first_pll_low = n;
      if (first_r0 == 0 && rst_out[0] === 1'b0) first_r0 = n;
      if (first_ready == 0 && ready === 1'b1) first_ready = n;
    end
    checks++;
    if (first_pll_low != 6) begin
      errors++;
      $display("FAIL nominal_pll_low edge %0d want 6", first_pll_low);
    end
    checks++;
    if (first_r0 != 16) begin
      errors++;
      $display("FAIL nominal_rst0_fall edge %0d want 16", first_r0);
    end
    checks++;
    if (first_ready != 20) begin
      errors++;
      $display("FAIL nominal_ready edge %0d want 20", first_ready);
    end
  endtask

  task automatic test_glitch();
    bit v;
    apply_reset();
    for (int n = 1; n <= 40; n++) begin
      v = !(n <= 6 || n == 12);
      step(v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch n=%0d got %b want %b", n, dut_vec(), exp_vec());
      end
      if (n == 27) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL glitch_early_ready got %b want 0", ready);
        end
      end
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL glitch_final_ready got %b want 1", ready);
    end
  endtask

  task automatic test_release_loss();
    apply_reset();
    for (int n = 1; n <= 45; n++) begin
      step(!(n == 17 || n == 18));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rel_loss n=%0d got %b want %b", n, dut_vec(), exp_vec());
      end
      if (n == 19) begin
        checks++;
        if (rst_out !== {N_RST{1'b1}}) begin
          errors++;
          $display("FAIL rel_loss_reassert got %b want all ones", rst_out);
        end
      end
    end
  endtask

  task automatic test_run_loss();
    apply_reset();
    for (int n = 1; n <= 70; n++) begin
      step(!(n >= 25 && n <= 27));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL run_loss n=%0d got %b want %b", n, dut_vec(), exp_vec());
      end
      if (n == 26 || n == 27) begin
        checks++;
        if ({rst_out, ready} !== {{N_RST{(n == 27)}}, (n == 26)}) begin
          errors++;
          $display("FAIL run_loss_timing n=%0d got rst=%b rdy=%b", n, rst_out, ready);
        end
      end
    end
    checks++;
    if ({ready, retries} !== {1'b1, {RW{1'b0}}}) begin
      errors++;
      $display("FAIL run_loss_final got rdy=%b retries=%0d want 1/0", ready, retries);
    end
  endtask

  task automatic test_no_lock();
    int retry_hi = 0;
    apply_reset();
    for (int n = 1; n <= 200; n++) begin
      step(1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL no_lock n=%0d got %b want %b", n, dut_vec(), exp_vec());
      end
      if (n > 6 && pll_rst === 1'b1 && fail_flag === 1'b0) retry_hi++;
    end
    checks++;
    if (retry_hi != PLLRST_CYC) begin
      errors++;
      $display("FAIL no_lock_pulse width %0d want %0d", retry_hi, PLLRST_CYC);
    end
    checks++;
    if ({fail_flag, pll_rst, retries} !== {1'b1, 1'b1, RW'(MAX_RETRY)}) begin
      errors++;
      $display("FAIL no_lock_final got fail=%b pll=%b retries=%0d", fail_flag, pll_rst, retries);
    end
  endtask

  task automatic test_fail_reset();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL fail_reset_async got %b want %b", dut_vec(), RESET_VEC);
    end
    step(1'b0);
    step(1'b0);
    rstn = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step(1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fail_reset n=%0d got %b want %b", n, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int n;
    int seg_len;
    bit seg_val;
    for (int it = 0; it < 8; it++) begin
      apply_reset();
      n = 0;
      while (n < 400) begin
        seg_val = ($urandom_range(0, 9) < 7);
        seg_len = $urandom_range(1, 24);
        for (int j = 0; j < seg_len && n < 400; j++) begin
          if ($urandom_range(0, 299) == 0) begin
            #2 rstn = 1'b0;
            #1;
            model_reset();
            checks++;
            if (dut_vec() !== RESET_VEC) begin
              errors++;
              $display("FAIL random_async it=%0d got %b want %b", it, dut_vec(), RESET_VEC);
            end
            step(1'b0);
            rstn = 1'b1;
          end
          step(seg_val);
          n++;
          checks++;
          if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random it=%0d n=%0d got %b want %b", it, n, dut_vec(), exp_vec());
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_release_loss();
    test_run_loss();
    test_no_lock();
    test_fail_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
